// File: rtl/rv32i_decode_queue_if.sv
// Fetch-to-execute channel of the decode queue: instruction intake on one side, decoded result stream on the other.
// The slave modport is the decode stage's view; the master modport is the surrounding pipeline's view.
interface rv32i_decode_queue_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [5:0]      out_op;
    logic [2:0]      out_fmt;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [31:0]     out_imm;
    logic            out_illegal;
    logic            out_halt;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_op, out_fmt, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_halt
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_op, out_fmt, out_rd, out_rs1, out_rs2,
               out_imm, out_illegal, out_halt
    );
endinterface

// File: rtl/rv32i_decode_queue.sv
// Buffered RV32I decode stage: decodes each accepted word and queues the result in a small FIFO
// toward execute; a HALT word stops intake until flushed.
module rv32i_decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    rv32i_decode_queue_if.slave  bus,
    output logic                 halted,
    output logic [CNT_W-1:0]     decoded_cnt,
    output logic [CNT_W-1:0]     illegal_cnt
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OP_ILL  = 6'd0,  OP_ADDI = 6'd1,  OP_SLTI = 6'd2,  OP_SLTIU = 6'd3;
    localparam logic [5:0] OP_ANDI = 6'd4,  OP_ORI  = 6'd5,  OP_XORI = 6'd6,  OP_SLLI  = 6'd7;
    localparam logic [5:0] OP_SRLI = 6'd8,  OP_SRAI = 6'd9,  OP_LUI  = 6'd10, OP_AUIPC = 6'd11;
    localparam logic [5:0] OP_ADD  = 6'd12, OP_SUB  = 6'd13, OP_SLT  = 6'd14, OP_SLTU  = 6'd15;
    localparam logic [5:0] OP_AND  = 6'd16, OP_OR   = 6'd17, OP_XOR  = 6'd18, OP_SLL   = 6'd19;
    localparam logic [5:0] OP_SRL  = 6'd20, OP_SRA  = 6'd21, OP_JAL  = 6'd22, OP_JALR  = 6'd23;
    localparam logic [5:0] OP_BEQ  = 6'd24, OP_BNE  = 6'd25, OP_BLT  = 6'd26, OP_BLTU  = 6'd27;
    localparam logic [5:0] OP_BGE  = 6'd28, OP_BGEU = 6'd29, OP_LW   = 6'd30, OP_LH    = 6'd31;
    localparam logic [5:0] OP_LHU  = 6'd32, OP_LB   = 6'd33, OP_LBU  = 6'd34, OP_SW    = 6'd35;
    localparam logic [5:0] OP_SH   = 6'd36, OP_SB   = 6'd37, OP_HALT = 6'd38;

    localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4, FMT_J = 3'd5, FMT_NONE = 3'd7;

    localparam logic [31:0] HALT_WORD = 32'h0001_0073;
    localparam logic [6:0]  F7_ZERO   = 7'b000_0000;
    localparam logic [6:0]  F7_ALT    = 7'b010_0000;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [5:0]      op;
        logic [2:0]      fmt;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [31:0]     imm;
        logic            illegal;
        logic            halt;
    } entry_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [5:0]  op_next;
    logic [2:0]  fmt_cand;
    logic [2:0]  fmt_next;
    logic        shamt_next;
    logic [31:0] imm_next;
    entry_t      dec;

    entry_t               mem_reg [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW:0]          count_reg;
    logic                 halted_reg;
    logic [CNT_W-1:0]     decoded_cnt_reg;
    logic [CNT_W-1:0]     illegal_cnt_reg;

    logic   full;
    logic   empty;
    logic   push;
    logic   pop;
    entry_t head;

    assign instr  = bus.in_instr;
    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];

    always_comb begin
        op_next    = OP_ILL;
        fmt_cand   = FMT_NONE;
        shamt_next = 1'b0;
        case (opcode)
            7'b0010011: begin
                fmt_cand = FMT_I;
                case (f3)
                    3'b000: op_next = OP_ADDI;
                    3'b010: op_next = OP_SLTI;
                    3'b011: op_next = OP_SLTIU;
                    3'b111: op_next = OP_ANDI;
                    3'b110: op_next = OP_ORI;
                    3'b100: op_next = OP_XORI;
                    3'b001: begin
                        shamt_next = 1'b1;
                        if (f7 == F7_ZERO) op_next = OP_SLLI;
                    end
                    3'b101: begin
                        shamt_next = 1'b1;
                        if (f7 == F7_ZERO)     op_next = OP_SRLI;
                        else if (f7 == F7_ALT) op_next = OP_SRAI;
                    end
                    default: ;
                endcase
            end
            7'b0110111: begin fmt_cand = FMT_U; op_next = OP_LUI;   end
            7'b0010111: begin fmt_cand = FMT_U; op_next = OP_AUIPC; end
            7'b0110011: begin
                fmt_cand = FMT_R;
                if (f7 == F7_ZERO) begin
                    case (f3)
                        3'b000:  op_next = OP_ADD;
                        3'b010:  op_next = OP_SLT;
                        3'b011:  op_next = OP_SLTU;
                        3'b111:  op_next = OP_AND;
                        3'b110:  op_next = OP_OR;
                        3'b100:  op_next = OP_XOR;
                        3'b001:  op_next = OP_SLL;
                        3'b101:  op_next = OP_SRL;
                        default: ;
                    endcase
                end else if (f7 == F7_ALT) begin
                    case (f3)
                        3'b000:  op_next = OP_SUB;
                        3'b101:  op_next = OP_SRA;
                        default: ;
                    endcase
                end
            end
            7'b1101111: begin fmt_cand = FMT_J; op_next = OP_JAL; end
            7'b1100111: begin
                fmt_cand = FMT_I;
                if (f3 == 3'b000) op_next = OP_JALR;
            end
            7'b1100011: begin
                fmt_cand = FMT_B;
                case (f3)
                    3'b000:  op_next = OP_BEQ;
                    3'b001:  op_next = OP_BNE;
                    3'b100:  op_next = OP_BLT;
                    3'b110:  op_next = OP_BLTU;
                    3'b101:  op_next = OP_BGE;
                    3'b111:  op_next = OP_BGEU;
                    default: ;
                endcase
            end
            7'b0000011: begin
                fmt_cand = FMT_I;
                case (f3)
                    3'b010:  op_next = OP_LW;
                    3'b001:  op_next = OP_LH;
                    3'b101:  op_next = OP_LHU;
                    3'b000:  op_next = OP_LB;
                    3'b100:  op_next = OP_LBU;
                    default: ;
                endcase
            end
            7'b0100011: begin
                fmt_cand = FMT_S;
                case (f3)
                    3'b010:  op_next = OP_SW;
                    3'b001:  op_next = OP_SH;
                    3'b000:  op_next = OP_SB;
                    default: ;
                endcase
            end
            // Only the exact HALT word is accepted from the SYSTEM space.
            7'b1110011: if (instr == HALT_WORD) op_next = OP_HALT;
            default: ;
        endcase
    end

    assign fmt_next = (op_next == OP_ILL) ? FMT_NONE : fmt_cand;

    always_comb begin
        imm_next = 32'd0;
        case (fmt_next)
            FMT_I:   imm_next = shamt_next ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
            FMT_S:   imm_next = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm_next = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U:   imm_next = {instr[31:12], 12'd0};
            FMT_J:   imm_next = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm_next = 32'd0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = bus.in_pc;
        dec.op      = op_next;
        dec.fmt     = fmt_next;
        dec.rd      = instr[11:7];
        dec.rs1     = instr[19:15];
        dec.rs2     = instr[24:20];
        dec.imm     = imm_next;
        dec.illegal = (op_next == OP_ILL);
        dec.halt    = (op_next == OP_HALT);
    end

    assign full  = (count_reg == (AW + 1)'(DEPTH));
    assign empty = (count_reg == '0);

    // Reset gates intake directly so in_ready is low for the whole time rst_n is asserted.
    assign bus.in_ready = rst_n & ~full & ~halted_reg & ~flush;
    assign push         = bus.in_valid & bus.in_ready;
    assign pop          = ~empty & bus.out_ready;

    always_ff @(posedge clk) begin
        if (push) mem_reg[wr_ptr_reg] <= dec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            halted_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
            if (push && dec.halt) halted_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            decoded_cnt_reg <= '0;
            illegal_cnt_reg <= '0;
        end else if (push) begin
            if (dec.illegal) begin
                if (illegal_cnt_reg != '1) illegal_cnt_reg <= illegal_cnt_reg + 1'b1;
            end else begin
                if (decoded_cnt_reg != '1) decoded_cnt_reg <= decoded_cnt_reg + 1'b1;
            end
        end
    end

    // Stale storage is never exposed: every head field reads zero while the queue is empty.
    assign head            = empty ? '0 : mem_reg[rd_ptr_reg];
    assign bus.out_valid   = ~empty;
    assign bus.out_pc      = head.pc;
    assign bus.out_op      = head.op;
    assign bus.out_fmt     = head.fmt;
    assign bus.out_rd      = head.rd;
    assign bus.out_rs1     = head.rs1;
    assign bus.out_rs2     = head.rs2;
    assign bus.out_imm     = head.imm;
    assign bus.out_illegal = head.illegal;
    assign bus.out_halt    = head.halt;

    assign halted      = halted_reg;
    assign decoded_cnt = decoded_cnt_reg;
    assign illegal_cnt = illegal_cnt_reg;
endmodule

// File: tb/tb_rv32i_decode_queue.sv
// Directed bench for rv32i_decode_queue: a decode vector table plus sequences for fill/full,
// HALT/flush, streaming with pointer wrap, counter saturation and mid-traffic reset.
module tb_rv32i_decode_queue;
    localparam int DEPTH = 4;
    localparam int PC_W  = 32;
    localparam int CNT_W = 4;
    localparam int NVEC  = 11;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flush = 1'b0;
    logic             halted;
    logic [CNT_W-1:0] decoded_cnt;
    logic [CNT_W-1:0] illegal_cnt;

    int checks   = 0;
    int failures = 0;

    rv32i_decode_queue_if #(.PC_W(PC_W)) bus ();

    rv32i_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .bus         (bus.slave),
        .halted      (halted),
        .decoded_cnt (decoded_cnt),
        .illegal_cnt (illegal_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [5:0]  op;
        logic [2:0]  fmt;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int sent;
        int rx;
        int stalls;

        vecs[0]  = '{32'h002081B3, 6'd12, 3'd0, 5'd3,  5'd1, 5'd2,  32'h0000_0000, 1'b0}; // ADD
        vecs[1]  = '{32'hFFF00093, 6'd1,  3'd1, 5'd1,  5'd0, 5'd31, 32'hFFFF_FFFF, 1'b0}; // ADDI -1
        vecs[2]  = '{32'hFE208EE3, 6'd24, 3'd3, 5'd29, 5'd1, 5'd2,  32'hFFFF_FFFC, 1'b0}; // BEQ -4
        vecs[3]  = '{32'h00000000, 6'd0,  3'd7, 5'd0,  5'd0, 5'd0,  32'h0000_0000, 1'b1};
        vecs[4]  = '{32'h00100073, 6'd0,  3'd7, 5'd0,  5'd0, 5'd1,  32'h0000_0000, 1'b1}; // EBREAK
        vecs[5]  = '{32'h123452B7, 6'd10, 3'd4, 5'd5,  5'd8, 5'd3,  32'h1234_5000, 1'b0}; // LUI
        vecs[6]  = '{32'h4030D093, 6'd9,  3'd1, 5'd1,  5'd1, 5'd3,  32'h0000_0003, 1'b0}; // SRAI
        vecs[7]  = '{32'h0020A423, 6'd35, 3'd2, 5'd8,  5'd1, 5'd2,  32'h0000_0008, 1'b0}; // SW 8
        vecs[8]  = '{32'h010000EF, 6'd22, 3'd5, 5'd1,  5'd0, 5'd16, 32'h0000_0010, 1'b0}; // JAL +16
        vecs[9]  = '{32'h40208033, 6'd13, 3'd0, 5'd0,  5'd1, 5'd2,  32'h0000_0000, 1'b0}; // SUB
        vecs[10] = '{32'h02208033, 6'd0,  3'd7, 5'd0,  5'd1, 5'd2,  32'h0000_0000, 1'b1}; // MUL

        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_pc     = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_op", 64'(bus.out_op), 64'd0);
        check("rst_out_imm", 64'(bus.out_imm), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_decoded_cnt", 64'(decoded_cnt), 64'd0);
        check("rst_illegal_cnt", 64'(illegal_cnt), 64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // decode table: one word at a time, checked one cycle after its push
        for (int v = 0; v < NVEC; v++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = vecs[v].instr;
            bus.in_pc    = 32'h1000 + 32'(v) * 4;
            @(negedge clk);
            check("vec_in_ready", 64'(bus.in_ready), 64'd1);
            check("vec_no_bypass", 64'(bus.out_valid), 64'd0);
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            $display("vec %0d instr=%08h op=%0d fmt=%0d imm=%08h ill=%0b", v, vecs[v].instr,
                     bus.out_op, bus.out_fmt, bus.out_imm, bus.out_illegal);
            check("vec_out_valid", 64'(bus.out_valid), 64'd1);
            check("vec_pc", 64'(bus.out_pc), 64'(32'h1000 + 32'(v) * 4));
            check("vec_op", 64'(bus.out_op), 64'(vecs[v].op));
            check("vec_fmt", 64'(bus.out_fmt), 64'(vecs[v].fmt));
            check("vec_rd", 64'(bus.out_rd), 64'(vecs[v].rd));
            check("vec_rs1", 64'(bus.out_rs1), 64'(vecs[v].rs1));
            check("vec_rs2", 64'(bus.out_rs2), 64'(vecs[v].rs2));
            check("vec_imm", 64'(bus.out_imm), 64'(vecs[v].imm));
            check("vec_illegal", 64'(bus.out_illegal), 64'(vecs[v].ill));
            check("vec_halt", 64'(bus.out_halt), 64'd0);
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
        @(negedge clk);
        check("tbl_empty", 64'(bus.out_valid), 64'd0);
        check("tbl_empty_op", 64'(bus.out_op), 64'd0);
        check("tbl_decoded_cnt", 64'(decoded_cnt), 64'd8);
        check("tbl_illegal_cnt", 64'(illegal_cnt), 64'd3);
        @(posedge clk); #1;

        // fill to full with out_ready low, then a single pop admits one more word
        accepted = 0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            bus.in_instr = {12'(accepted), 20'h00013};
            bus.in_pc    = 32'h100 + 32'(accepted) * 4;
            @(negedge clk);
            if (bus.in_ready) accepted++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        $display("fill accepted=%0d in_ready=%0b", accepted, bus.in_ready);
        check("full_accepted", 64'(accepted), 64'd4);
        check("full_in_ready", 64'(bus.in_ready), 64'd0);
        check("full_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("pop_head_pc", 64'(bus.out_pc), 64'h100);
        check("pop_head_imm", 64'(bus.out_imm), 64'd0);
        check("pop_in_ready_same_cycle", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_instr  = {12'(accepted), 20'h00013};
        bus.in_pc     = 32'h100 + 32'(accepted) * 4;
        @(negedge clk);
        check("pop_in_ready_next", 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) accepted++;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("refill_accepted", 64'(accepted), 64'd5);
        bus.out_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            @(negedge clk);
            $display("drain k=%0d pc=%08h imm=%0d", k, bus.out_pc, bus.out_imm);
            check("drain_valid", 64'(bus.out_valid), 64'd1);
            check("drain_pc", 64'(bus.out_pc), 64'(32'h100 + 32'(k) * 4));
            check("drain_imm", 64'(bus.out_imm), 64'(k));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("drain_empty", 64'(bus.out_valid), 64'd0);
        check("drain_decoded_cnt", 64'(decoded_cnt), 64'd13);
        @(posedge clk); #1;

        // HALT stops intake; the following ADD is refused until flush
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h00010073;
        bus.in_pc    = 32'h300;
        @(negedge clk);
        check("halt_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_instr = 32'h002081B3;
        bus.in_pc    = 32'h304;
        repeat (2) begin
            @(negedge clk);
            $display("halt halted=%0b in_ready=%0b op=%0d", halted, bus.in_ready, bus.out_op);
            check("halt_halted", 64'(halted), 64'd1);
            check("halt_blocks_intake", 64'(bus.in_ready), 64'd0);
            check("halt_head_op", 64'(bus.out_op), 64'd38);
            check("halt_head_flag", 64'(bus.out_halt), 64'd1);
            check("halt_head_fmt", 64'(bus.out_fmt), 64'd7);
            @(posedge clk); #1;
        end
        check("halt_decoded_cnt", 64'(decoded_cnt), 64'd14);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);
        $display("flush out_valid=%0b halted=%0b", bus.out_valid, halted);
        check("flush_empty", 64'(bus.out_valid), 64'd0);
        check("flush_halted", 64'(halted), 64'd0);
        check("flush_in_ready_after", 64'(bus.in_ready), 64'd1);
        check("flush_decoded_cnt", 64'(decoded_cnt), 64'd14);
        @(posedge clk); #1;

        // simultaneous push and pop for 2*DEPTH words
        sent = 0; rx = 0; stalls = 0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && rx < 2 * DEPTH; c++) begin
            bus.in_valid = (sent < 2 * DEPTH);
            bus.in_instr = {12'(sent), 20'h00013};
            bus.in_pc    = 32'h200 + 32'(sent) * 4;
            @(negedge clk);
            if (bus.out_valid) begin
                $display("stream rx=%0d pc=%08h imm=%0d", rx, bus.out_pc, bus.out_imm);
                check("stream_pc", 64'(bus.out_pc), 64'(32'h200 + 32'(rx) * 4));
                check("stream_imm", 64'(bus.out_imm), 64'(rx));
                check("stream_op", 64'(bus.out_op), 64'd1);
                rx++;
            end
            if (bus.in_valid && !bus.in_ready) stalls++;
            if (bus.in_valid && bus.in_ready) sent++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        check("stream_received", 64'(rx), 64'(2 * DEPTH));
        check("stream_stalls", 64'(stalls), 64'd0);
        @(negedge clk);
        check("sat_decoded_cnt", 64'(decoded_cnt), 64'd15);
        check("sat_illegal_cnt", 64'(illegal_cnt), 64'd3);
        @(posedge clk); #1;

        // reset in the middle of traffic discards queued entries and counters
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h002081B3;
        repeat (2) begin @(posedge clk); #1; end
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        check("midrst_decoded_cnt", 64'(decoded_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_after_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_after_in_ready", 64'(bus.in_ready), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
